// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes share one port with late mul/div
// results, an MDU busy scoreboard answers hazard queries, and a starving MDU forces a stall.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wreg,
    input  logic [31:0] pipe_wdata,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_reg,
    input  logic        md_valid,
    input  logic [4:0]  md_wreg,
    input  logic [31:0] md_wdata,
    output logic        md_ready,
    input  logic [4:0]  q_reg1,
    input  logic [4:0]  q_reg2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        pipe_stall,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic        err_drop
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] busy_q, busy_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        stall_q;
    logic        err_q, err_d;
    logic        pipe_req, xfer, blocked;
    logic [4:0]  cnt_inc;

    assign pipe_req = pipe_we && (pipe_wreg != 5'd0);
    assign md_ready = reset && md_valid && ((state_q == ST_FORCE) || !pipe_req);
    assign xfer     = md_valid && md_ready;
    assign blocked  = md_valid && !md_ready;
    assign cnt_inc  = {1'b0, cnt_q} + 5'd1;

    // cnt counts blocked cycles including the current one; reaching the limit forces a stall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (blocked) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd1;
                end
            end
            ST_WAIT: begin
                if (blocked) begin
                    cnt_d = cnt_inc[3:0];
                    if (cnt_inc >= 5'(STARVE_LIMIT)) state_d = ST_FORCE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_FORCE: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Address/data hold their last value when nothing writes
    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (xfer) begin
            we_d    = (md_wreg != 5'd0);
            wreg_d  = md_wreg;
            wdata_d = md_wdata;
            if (pipe_req) err_d = 1'b1;
        end else if (pipe_req) begin
            we_d    = 1'b1;
            wreg_d  = pipe_wreg;
            wdata_d = pipe_wdata;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the register busy
    always_comb begin
        busy_d = busy_q;
        if (xfer && (md_wreg != 5'd0)) busy_d[md_wreg] = 1'b0;
        if (md_issue && (md_issue_reg != 5'd0)) busy_d[md_issue_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            stall_q <= (state_d == ST_FORCE);
            err_q   <= err_d;
        end
    end

    assign q_busy1        = busy_q[q_reg1];
    assign q_busy2        = busy_q[q_reg2];
    assign pipe_stall     = stall_q;
    assign RegWrite       = we_q;
    assign Write_register = wreg_q;
    assign Write_data     = wdata_q;
    assign err_drop       = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_wreg;
    logic [31:0] pipe_wdata;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_valid;
    logic [4:0]  md_wreg;
    logic [31:0] md_wdata;
    logic        md_ready;
    logic [4:0]  q_reg1, q_reg2;
    logic        q_busy1, q_busy2;
    logic        pipe_stall;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic        err_drop;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
        .md_issue(md_issue), .md_issue_reg(md_issue_reg),
        .md_valid(md_valid), .md_wreg(md_wreg), .md_wdata(md_wdata), .md_ready(md_ready),
        .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .pipe_stall(pipe_stall), .RegWrite(RegWrite), .Write_register(Write_register),
        .Write_data(Write_data), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_wreg = 0; pipe_wdata = 0;
        md_issue = 0; md_issue_reg = 0;
        md_valid = 0; md_wreg = 0; md_wdata = 0;
        q_reg1 = 0; q_reg2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        md_valid = 1; md_wreg = 5'd4;
        #2;
        n_checks++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_md_ready got=%b exp=0", md_ready); end
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_RegWrite got=%b exp=0", RegWrite); end
        n_checks++; if (Write_register !== 5'd0) begin n_fail++; $display("FAIL reset_Write_register got=%0d exp=0", Write_register); end
        n_checks++; if (Write_data !== 32'd0) begin n_fail++; $display("FAIL reset_Write_data got=%h exp=0", Write_data); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
        n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err_drop got=%b exp=0", err_drop); end
        do_reset();
    endtask

    task automatic test_pipe_write();
        do_reset();
        pipe_we = 1; pipe_wreg = 5'd5; pipe_wdata = 32'h1234;
        tick();
        pipe_we = 0;
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL pipe_RegWrite got=%b exp=1", RegWrite); end
        n_checks++; if (Write_register !== 5'd5) begin n_fail++; $display("FAIL pipe_Write_register got=%0d exp=5", Write_register); end
        n_checks++; if (Write_data !== 32'h1234) begin n_fail++; $display("FAIL pipe_Write_data got=%h exp=1234", Write_data); end
        pipe_we = 1; pipe_wreg = 5'd0; pipe_wdata = 32'hFFFF;
        tick();
        pipe_we = 0;
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL pipe_r0_RegWrite got=%b exp=0", RegWrite); end
    endtask

    task automatic test_mdu_scoreboard();
        do_reset();
        md_issue = 1; md_issue_reg = 5'd8;
        tick();
        md_issue = 0;
        q_reg1 = 5'd8; q_reg2 = 5'd0;
        #1;
        n_checks++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set got=%b exp=1", q_busy1); end
        n_checks++; if (q_busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_r0 got=%b exp=0", q_busy2); end
        md_valid = 1; md_wreg = 5'd8; md_wdata = 32'hCAFE;
        #1;
        n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL sb_md_ready got=%b exp=1", md_ready); end
        tick();
        md_valid = 0;
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd8 || Write_data !== 32'hCAFE)
            begin n_fail++; $display("FAIL sb_md_write got=%b/%0d/%h exp=1/8/cafe", RegWrite, Write_register, Write_data); end
        n_checks++; if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear got=%b exp=0", q_busy1); end
    endtask

    task automatic test_starve_force();
        do_reset();
        md_valid = 1; md_wreg = 5'd12; md_wdata = 32'hBEEF;
        pipe_we = 1; pipe_wreg = 5'd5;
        for (int i = 0; i < LIMIT; i++) begin
            pipe_wdata = 32'h100 + i;
            #1;
            n_checks++; if (md_ready !== 1'b0 || pipe_stall !== 1'b0)
                begin n_fail++; $display("FAIL starve_blocked cyc=%0d ready=%b stall=%b exp=0/0", i, md_ready, pipe_stall); end
            tick();
            n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd5 || Write_data !== 32'h100 + i)
                begin n_fail++; $display("FAIL starve_pipe_write cyc=%0d got=%b/%0d/%h", i, RegWrite, Write_register, Write_data); end
        end
        pipe_wreg = 5'd3; pipe_wdata = 32'h3333;
        #1;
        n_checks++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL force_stall got=%b exp=1", pipe_stall); end
        n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL force_md_ready got=%b exp=1", md_ready); end
        tick();
        md_valid = 0; pipe_we = 0;
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd12 || Write_data !== 32'hBEEF)
            begin n_fail++; $display("FAIL force_md_write got=%b/%0d/%h exp=1/12/beef", RegWrite, Write_register, Write_data); end
        n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL force_err_drop got=%b exp=1", err_drop); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL force_exit_stall got=%b exp=0", pipe_stall); end
        tick();
        tick();
        n_checks++; if (err_drop !== 1'b1 || RegWrite !== 1'b0)
            begin n_fail++; $display("FAIL err_sticky err=%b regwrite=%b exp=1/0", err_drop, RegWrite); end
    endtask

    task automatic test_set_wins();
        do_reset();
        md_issue = 1; md_issue_reg = 5'd9;
        tick();
        md_valid = 1; md_wreg = 5'd9; md_wdata = 32'h99;
        tick();
        md_issue = 0; md_valid = 0;
        q_reg1 = 5'd9;
        #1;
        n_checks++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL setwins_busy got=%b exp=1", q_busy1); end
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd9)
            begin n_fail++; $display("FAIL setwins_write got=%b/%0d exp=1/9", RegWrite, Write_register); end
        md_valid = 1; md_wreg = 5'd0; md_wdata = 32'hDEAD;
        #1;
        n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL r0_md_ready got=%b exp=1", md_ready); end
        tick();
        md_valid = 0;
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL r0_RegWrite got=%b exp=0", RegWrite); end
        n_checks++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL r0_busy_kept got=%b exp=1", q_busy1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        md_issue = 1; md_issue_reg = 5'd7;
        tick();
        md_issue_reg = 5'd20;
        tick();
        md_issue = 0;
        md_valid = 1; md_wreg = 5'd7; md_wdata = 32'h77;
        pipe_we = 1; pipe_wreg = 5'd2; pipe_wdata = 32'h22;
        tick();
        tick();
        q_reg1 = 5'd7; q_reg2 = 5'd20;
        #1;
        n_checks++; if (q_busy1 !== 1'b1 || q_busy2 !== 1'b1 || RegWrite !== 1'b1)
            begin n_fail++; $display("FAIL mid_pre busy=%b%b regwrite=%b exp=11/1", q_busy1, q_busy2, RegWrite); end
        reset = 0;
        #1;
        n_checks++; if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0)
            begin n_fail++; $display("FAIL mid_write got=%b/%0d/%h exp=0/0/0", RegWrite, Write_register, Write_data); end
        n_checks++; if (md_ready !== 1'b0 || pipe_stall !== 1'b0 || err_drop !== 1'b0)
            begin n_fail++; $display("FAIL mid_ctrl ready=%b stall=%b err=%b exp=0/0/0", md_ready, pipe_stall, err_drop); end
        n_checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0)
            begin n_fail++; $display("FAIL mid_busy got=%b%b exp=00", q_busy1, q_busy2); end
        idle_inputs();
        q_reg1 = 5'd7;
        @(posedge clk);
        #1 reset = 1;
        md_valid = 1; md_wreg = 5'd7; md_wdata = 32'h70;
        pipe_we = 1; pipe_wreg = 5'd2;
        for (int i = 0; i < LIMIT - 1; i++) tick();
        #1;
        n_checks++; if (pipe_stall !== 1'b0 || md_ready !== 1'b0)
            begin n_fail++; $display("FAIL mid_restart stall=%b ready=%b exp=0/0", pipe_stall, md_ready); end
        tick();
        #1;
        n_checks++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL mid_restart_force got=%b exp=1", pipe_stall); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit          m_busy [32];
        int          m_blocked;
        bit          m_force, m_err, hold;
        bit          pr, exp_rdy, xf, e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        do_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_blocked = 0; m_force = 0; m_err = 0; hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold && $urandom_range(0, 9) != 0) begin
                md_valid = 1;
            end else begin
                md_valid = $urandom_range(0, 1);
                md_wreg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md_wdata = $urandom;
            end
            pipe_we      = ($urandom_range(0, 3) != 0);
            pipe_wreg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_wdata   = $urandom;
            md_issue     = ($urandom_range(0, 3) == 0);
            md_issue_reg = 5'($urandom_range(0, 31));
            q_reg1       = 5'($urandom_range(0, 31));
            q_reg2       = 5'($urandom_range(0, 31));
            #1;
            pr      = pipe_we && (pipe_wreg != 0);
            exp_rdy = md_valid && (m_force || !pr);
            xf      = md_valid && exp_rdy;
            n_checks++; if (md_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_md_ready cyc=%0d got=%b exp=%b", c, md_ready, exp_rdy); end
            n_checks++; if (pipe_stall !== m_force) begin n_fail++; $display("FAIL rnd_pipe_stall cyc=%0d got=%b exp=%b", c, pipe_stall, m_force); end
            n_checks++; if (q_busy1 !== m_busy[q_reg1]) begin n_fail++; $display("FAIL rnd_q_busy1 cyc=%0d reg=%0d got=%b exp=%b", c, q_reg1, q_busy1, m_busy[q_reg1]); end
            n_checks++; if (q_busy2 !== m_busy[q_reg2]) begin n_fail++; $display("FAIL rnd_q_busy2 cyc=%0d reg=%0d got=%b exp=%b", c, q_reg2, q_busy2, m_busy[q_reg2]); end
            e_we = 0; e_reg = 0; e_data = 0;
            if (xf) begin
                e_we = (md_wreg != 0); e_reg = md_wreg; e_data = md_wdata;
                if (pr) m_err = 1;
                if (md_wreg != 0) m_busy[md_wreg] = 0;
            end else if (pr) begin
                e_we = 1; e_reg = pipe_wreg; e_data = pipe_wdata;
            end
            if (md_issue && md_issue_reg != 0) m_busy[md_issue_reg] = 1;
            if (xf) begin
                m_blocked = 0; m_force = 0;
            end else if (md_valid) begin
                m_blocked++;
                if (m_blocked >= LIMIT && m_blocked >= 2) m_force = 1;
            end else if (!m_force) begin
                m_blocked = 0;
            end
            hold = md_valid && !exp_rdy;
            tick();
            n_checks++; if (RegWrite !== e_we) begin n_fail++; $display("FAIL rnd_RegWrite cyc=%0d got=%b exp=%b", c, RegWrite, e_we); end
            if (e_we) begin
                n_checks++; if (Write_register !== e_reg || Write_data !== e_data)
                    begin n_fail++; $display("FAIL rnd_write cyc=%0d got=%0d/%h exp=%0d/%h", c, Write_register, Write_data, e_reg, e_data); end
            end
            n_checks++; if (err_drop !== m_err) begin n_fail++; $display("FAIL rnd_err_drop cyc=%0d got=%b exp=%b", c, err_drop, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #2;
        test_reset();
        test_pipe_write();
        test_mdu_scoreboard();
        test_starve_force();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Parameters
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive blocked MDU cycles before a pipeline stall is forced (legal range 1..15).

Interface
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port pipe_we, input, 1, the pipeline writeback write request.
REQ-005 The block SHALL have port pipe_wreg, input, 5, the pipeline destination register.
REQ-006 The block SHALL have port pipe_wdata, input, 32, the pipeline write data.
REQ-007 The block SHALL have port md_issue, input, 1, pulsed when a mul/div op issues.
REQ-008 The block SHALL have port md_issue_reg, input, 5, the mul/div destination at issue.
REQ-009 The block SHALL have port md_valid, input, 1, indicating a mul/div result is offered.
REQ-010 The block SHALL have port md_wreg, input, 5, the mul/div result destination.
REQ-011 The block SHALL have port md_wdata, input, 32, the mul/div result data.
REQ-012 The block SHALL have port md_ready, output, 1, indicating the result is accepted this cycle.
REQ-013 The block SHALL have ports q_reg1 and q_reg2, input, 5 each, the hazard-unit scoreboard query addresses.
REQ-014 The block SHALL have ports q_busy1 and q_busy2, output, 1 each, asserted when the queried register has a pending mul/div write.
REQ-015 The block SHALL have port pipe_stall, output, 1, the pipeline freeze request.
REQ-016 The block SHALL have port RegWrite, output, 1, the register-file write enable.
REQ-017 The block SHALL have port Write_register, output, 5, the register-file write address.
REQ-018 The block SHALL have port Write_data, output, 32, the register-file write data.
REQ-019 The block SHALL have port err_drop, output, 1, a sticky flag set when a pipeline write is dropped.

Function
REQ-020 pipe_req is defined as pipe_we && pipe_wreg!=0; writes to $0 SHALL never occupy the port.
REQ-021 The FSM SHALL have three states: IDLE, WAIT and FORCE; pipe_stall SHALL be 1 only in FORCE (registered Moore output).
REQ-022 md_ready SHALL equal md_valid && (state==FORCE || !pipe_req).
REQ-023 A transfer SHALL occur when md_valid && md_ready; md_wreg and md_wdata SHALL be held stable by the source while md_valid && !md_ready.
REQ-024 Port selection: an MDU transfer SHALL drive the write port with md_wreg/md_wdata; otherwise pipe_req SHALL drive it with pipe_wreg/pipe_wdata; otherwise RegWrite SHALL be 0.
REQ-025 RegWrite, Write_register and Write_data SHALL be registered, appearing exactly 1 cycle after the selecting cycle.
REQ-026 An MDU transfer with md_wreg==0 SHALL be accepted with RegWrite=0 and no scoreboard change.
REQ-027 IDLE->WAIT SHALL occur when md_valid && !md_ready; the starve counter SHALL be set to 1.
REQ-028 In WAIT, each further blocked cycle SHALL increment the counter; when counter==STARVE_LIMIT and the transfer is still blocked, the next state SHALL be FORCE.
REQ-029 WAIT->IDLE SHALL occur on transfer or on md_valid dropping; the counter SHALL clear.
REQ-030 In FORCE the MDU SHALL always win; if pipe_req is also asserted, the pipeline write SHALL be discarded and err_drop set (sticky until reset). FORCE->IDLE SHALL occur on transfer.
REQ-031 The scoreboard SHALL be a 31-entry busy vector (regs 1..31): set on md_issue with md_issue_reg!=0, cleared on an MDU transfer of md_wreg; when set and clear hit the same register in one cycle, set SHALL win.
REQ-032 q_busyN SHALL be combinational from the registered vector, and SHALL be 0 for q_regN==0.

Reset
REQ-033 reset low SHALL asynchronously force: state IDLE, counter 0, scoreboard all 0, RegWrite 0, Write_register 0, Write_data 0, pipe_stall 0, err_drop 0; md_ready SHALL be 0 while reset is low.
REQ-034 Reset mid-operation SHALL discard any blocked MDU result and all pending busy bits.

Verification
REQ-035 Bench: pipe_we=1, pipe_wreg=5, pipe_wdata=0x1234 -> next cycle RegWrite=1, Write_register=5, Write_data=0x1234.
REQ-036 Bench: md_issue with md_issue_reg=8, then q_reg1=8 -> q_busy1=1; md_valid with md_wreg=8, md_wdata=0xCAFE and no pipe_req -> md_ready=1, write appears 1 cycle later, and q_busy1=0 after the edge.
REQ-037 Bench: md_valid held and pipe_req every cycle with STARVE_LIMIT=4 -> md_ready=0 for 4 cycles, then pipe_stall=1, md_ready=1, MDU write committed, then return to IDLE with pipe_stall=0.
REQ-038 Bench: in FORCE drive pipe_we=1, pipe_wreg=3 -> MDU data written, reg 3 not written, err_drop=1 and held.
REQ-039 Bench: same cycle md_issue reg 9 and MDU transfer to reg 9 -> busy[9] stays 1; md_wreg=0 transfer -> RegWrite=0.
REQ-040 Bench: assert reset during WAIT with busy bits set -> all outputs 0 immediately, q_busy=0, state IDLE.
